// File: rtl/bus_arbiter2.sv
// Two-master round-robin arbiter and sequencer for the peripheral bus.
// Serialises one transaction at a time, decodes the slave and returns read data with an ack pulse.
module bus_arbiter2 #(
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 5,
    parameter int RD_LAT  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    // Handshake: a master raises req with we/addr/wdata and holds it until its
    // one-cycle ack; fields are latched at grant, and a req still high once the
    // arbiter is back in IDLE is taken as a new transaction.
    input  logic                       m0_req,
    input  logic                       m0_we,
    input  logic [DATA_W-1:0]          m0_addr,
    input  logic [DATA_W-1:0]          m0_wdata,
    output logic                       m0_ack,
    input  logic                       m1_req,
    input  logic                       m1_we,
    input  logic [DATA_W-1:0]          m1_addr,
    input  logic [DATA_W-1:0]          m1_wdata,
    output logic                       m1_ack,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       m_err,
    output logic                       bus_we,
    output logic [DATA_W-1:0]          bus_addr,
    output logic [DATA_W-1:0]          bus_wdata,
    output logic [NUM_SLV-1:0]         bus_sel,
    input  logic [NUM_SLV*DATA_W-1:0]  s_rdata,
    output logic                       busy,
    output logic                       gnt_id
);

    localparam int HI_W  = DATA_W - 8;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 last_gnt_q;
    logic                 gnt_q;
    logic                 we_q;
    logic                 mapped_q;
    logic [DATA_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [NUM_SLV-1:0]   sel_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DATA_W-1:0]    rdata_q;

    logic                 any_req;
    logic                 win;
    logic                 win_we;
    logic [DATA_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;
    logic [NUM_SLV-1:0]   dec_sel;
    logic                 dec_hit;
    logic [DATA_W-1:0]    rd_slice;

    // Slave 0 sits at page 0x000000, slave i>0 at page 0x000020+i.
    function automatic logic [HI_W-1:0] slv_base(input int idx);
        if (idx == 0) begin
            return '0;
        end
        return HI_W'(32'h20 + idx);
    endfunction

    // When both request, the master that did not win last time goes first.
    always_comb begin
        any_req   = m0_req | m1_req;
        win       = (m0_req && m1_req) ? ~last_gnt_q : m1_req;
        win_we    = win ? m1_we    : m0_we;
        win_addr  = win ? m1_addr  : m0_addr;
        win_wdata = win ? m1_wdata : m0_wdata;
    end

    always_comb begin
        dec_sel = '0;
        dec_hit = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (win_addr[DATA_W-1:8] == slv_base(i)) begin
                dec_sel[i] = 1'b1;
                dec_hit    = 1'b1;
            end
        end
    end

    always_comb begin
        rd_slice = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) begin
                rd_slice = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (any_req) state_d = S_ADDR;
            S_ADDR: state_d = (we_q || !mapped_q) ? S_DONE : S_WAIT;
            S_WAIT: if (cnt_q == '0) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_gnt_q <= 1'b1;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            mapped_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        gnt_q      <= win;
                        last_gnt_q <= win;
                        we_q       <= win_we;
                        addr_q     <= win_addr;
                        wdata_q    <= win_wdata;
                        sel_q      <= dec_sel;
                        mapped_q   <= dec_hit;
                    end
                end
                S_ADDR: cnt_q <= CNT_W'(RD_LAT - 1);
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        rdata_q <= rd_slice;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m_rdata   = '0;
        m_err     = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_sel   = '0;
        busy      = (state_q != S_IDLE);
        gnt_id    = gnt_q;
        case (state_q)
            S_ADDR: begin
                bus_addr  = addr_q;
                bus_wdata = wdata_q;
                bus_sel   = sel_q;
                bus_we    = we_q & mapped_q;
            end
            S_WAIT: begin
                bus_addr  = addr_q;
                bus_wdata = wdata_q;
                bus_sel   = sel_q;
            end
            S_DONE: begin
                m0_ack  = ~gnt_q;
                m1_ack  = gnt_q;
                m_rdata = (!we_q && mapped_q) ? rdata_q : '0;
                m_err   = ~mapped_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Bench for bus_arbiter2: directed literal checks plus randomized two-master traffic
// compared every cycle against a transaction-level latency model.
module tb_bus_arbiter2;

    localparam int DW     = 32;
    localparam int NS     = 5;
    localparam int RD_LAT = 3;

    logic            clk;
    logic            reset;
    logic            m0_req, m0_we, m1_req, m1_we;
    logic [DW-1:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic            m0_ack, m1_ack;
    logic [DW-1:0]   m_rdata;
    logic            m_err;
    logic            bus_we;
    logic [DW-1:0]   bus_addr, bus_wdata;
    logic [NS-1:0]   bus_sel;
    logic [NS*DW-1:0] s_rdata;
    logic            busy;
    logic            gnt_id;

    int total = 0;
    int bad   = 0;

    logic [0:0] exp_q[$];
    logic [0:0] ack_q[$];

    bus_arbiter2 #(.DATA_W(DW), .NUM_SLV(NS), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
        .m_rdata(m_rdata), .m_err(m_err),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .s_rdata(s_rdata), .busy(busy), .gnt_id(gnt_id)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transaction is granted at an edge; k counts cycles since that grant.
    // Cycle 1 is the address cycle, cycle L the ack, with L = 2 or 2+RD_LAT.
    bit          mdl_started = 0;
    bit          mdl_act = 0;
    bit          mdl_last = 1;
    bit          mdl_own = 0;
    bit          mdl_we = 0;
    bit          mdl_map = 0;
    int          mdl_k = 0;
    int          mdl_len = 0;
    logic [31:0] mdl_addr = '0, mdl_wdata = '0, mdl_cap = '0;
    logic [4:0]  mdl_sel = '0;

    function automatic logic [4:0] model_dec(input logic [31:0] a);
        logic [23:0] hi;
        hi = a[31:8];
        if (hi == 24'h0) return 5'b00001;
        if (hi >= 24'h21 && hi <= 24'h24) return 5'b00001 << (hi - 24'h20);
        return 5'b00000;
    endfunction

    function automatic logic [31:0] slice_of(input logic [NS*DW-1:0] s, input logic [4:0] sel);
        for (int i = 0; i < NS; i++) begin
            if (sel[i]) return s[i*DW +: DW];
        end
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        mdl_started = 1;
        if (!reset) begin
            mdl_act  = 0;
            mdl_last = 1;
        end else if (mdl_act) begin
            if (mdl_k == mdl_len) begin
                mdl_act = 0;
            end else begin
                if (mdl_k == mdl_len - 1 && !mdl_we && mdl_map)
                    mdl_cap = slice_of(s_rdata, mdl_sel);
                mdl_k++;
            end
        end else if (m0_req || m1_req) begin
            mdl_own   = (m0_req && m1_req) ? !mdl_last : m1_req;
            mdl_last  = mdl_own;
            mdl_we    = mdl_own ? m1_we : m0_we;
            mdl_addr  = mdl_own ? m1_addr : m0_addr;
            mdl_wdata = mdl_own ? m1_wdata : m0_wdata;
            mdl_sel   = model_dec(mdl_addr);
            mdl_map   = (mdl_sel != 0);
            mdl_len   = (mdl_we || !mdl_map) ? 2 : 2 + RD_LAT;
            mdl_k     = 1;
            mdl_act   = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [4:0]  e_sel;
        bit          e_we, e_ack0, e_ack1, e_err;
        if (mdl_started) begin
            e_addr = '0; e_wdata = '0; e_sel = '0; e_we = 0;
            e_ack0 = 0; e_ack1 = 0; e_rdata = '0; e_err = 0;
            if (mdl_act && mdl_k < mdl_len) begin
                e_addr  = mdl_addr;
                e_wdata = mdl_wdata;
                e_sel   = mdl_sel;
                e_we    = (mdl_k == 1) && mdl_we && mdl_map;
            end else if (mdl_act) begin
                e_ack0  = !mdl_own;
                e_ack1  = mdl_own;
                e_rdata = (!mdl_we && mdl_map) ? mdl_cap : 32'h0;
                e_err   = !mdl_map;
            end
            check("busy", busy, mdl_act);
            check("bus_addr", bus_addr, e_addr);
            check("bus_wdata", bus_wdata, e_wdata);
            check("bus_sel", bus_sel, e_sel);
            check("bus_we", bus_we, e_we);
            check("m0_ack", m0_ack, e_ack0);
            check("m1_ack", m1_ack, e_ack1);
            if (mdl_act) check("gnt_id", gnt_id, mdl_own);
            if (e_ack0 || e_ack1) begin
                check("m_rdata", m_rdata, e_rdata);
                check("m_err", m_err, e_err);
            end
            if (m0_ack) ack_q.push_back(1'b0);
            if (m1_ack) ack_q.push_back(1'b1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_m(input int m, input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic release_m(input int m);
        @(posedge clk); #1;
        if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    // Raises req and waits for the ack; lat counts cycles from the request cycle.
    task automatic run_txn(input int m, input bit we, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd, output bit er,
                           output bit any_we, output logic [4:0] any_sel);
        bit got;
        got = 0; lat = 0; rd = '0; er = 0; any_we = 0; any_sel = '0;
        @(posedge clk); #1;
        set_m(m, 1'b1, we, a, d);
        while (!got && lat < 60) begin
            @(negedge clk);
            if ((m == 0) ? m0_ack : m1_ack) begin
                got = 1; rd = m_rdata; er = m_err;
            end else begin
                any_we  = any_we | bus_we;
                any_sel = any_sel | bus_sel;
                lat++;
            end
        end
        check("ack_seen", got, 1'b1);
    endtask

    function automatic logic [31:0] rand_addr();
        int kind;
        kind = $urandom_range(0, 6);
        case (kind)
            0: return {24'h000000, 8'($urandom)};
            1, 2, 3, 4: return {24'h000020 + 24'(kind), 8'($urandom)};
            5: return {(($urandom_range(0, 1) == 1) ? 24'h000025 : 24'h000020), 8'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int          lat;
        logic [31:0] rd;
        bit          er, aw;
        logic [4:0]  asel;
        int          n_ack;

        reset = 1'b0;
        set_m(0, 1'b1, 1'b1, 32'h0000_2204, 32'h5);
        set_m(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        s_rdata = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'hDEAD_BEEF};

        // Reset held with both masters requesting.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_busy", busy, 1'b0);
            check("rst_sel", bus_sel, 5'b0);
            check("rst_we", bus_we, 1'b0);
            check("rst_addr", bus_addr, 32'h0);
            check("rst_acks", {m0_ack, m1_ack}, 2'b00);
            check("rst_rdata_err", {m_rdata, m_err}, 33'h0);
            check("rst_gnt", gnt_id, 1'b0);
        end
        @(posedge clk); #1;
        reset = 1'b1;

        // Cycle 0 is this IDLE cycle; m0 wins the first tie and writes GPOB.
        @(negedge clk);
        @(negedge clk);
        check("wr_gnt", gnt_id, 1'b0);
        check("wr_sel", bus_sel, 5'b00100);
        check("wr_we", bus_we, 1'b1);
        check("wr_addr", bus_addr, 32'h0000_2204);
        check("wr_wdata", bus_wdata, 32'h5);
        @(negedge clk);
        check("wr_ack", {m0_ack, m1_ack}, 2'b10);
        check("wr_err", m_err, 1'b0);
        @(posedge clk); #1;
        m0_req = 1'b0;
        @(negedge clk);
        check("bubble_busy", busy, 1'b0);
        // m1 has waited; its RAM read is granted from this bubble.
        @(negedge clk);
        check("rd_gnt", gnt_id, 1'b1);
        check("rd_sel", bus_sel, 5'b00001);
        check("rd_we", bus_we, 1'b0);
        repeat (RD_LAT) begin
            @(negedge clk);
            check("rd_wait_sel", bus_sel, 5'b00001);
            check("rd_wait_we", bus_we, 1'b0);
            check("rd_wait_ack", {m0_ack, m1_ack}, 2'b00);
        end
        @(negedge clk);
        check("rd_ack", {m0_ack, m1_ack}, 2'b01);
        check("rd_data", m_rdata, 32'hDEAD_BEEF);
        release_m(1);

        // Unmapped write.
        run_txn(0, 1'b1, 32'h0000_3000, 32'hAA, lat, rd, er, aw, asel);
        check("unm_lat", lat, 2);
        check("unm_err", er, 1'b1);
        check("unm_rdata", rd, 32'h0);
        check("unm_we_never", aw, 1'b0);
        check("unm_sel_never", asel, 5'b0);
        release_m(0);

        // Mapped reads and near-miss pages.
        run_txn(1, 1'b0, 32'h0000_0010, 32'h0, lat, rd, er, aw, asel);
        check("ram_lat", lat, 2 + RD_LAT);
        check("ram_data", rd, 32'hDEAD_BEEF);
        release_m(1);
        run_txn(0, 1'b0, 32'h0000_24FC, 32'h0, lat, rd, er, aw, asel);
        check("gpod_lat", lat, 5);
        check("gpod_data", rd, 32'h4444_0004);
        check("gpod_err", er, 1'b0);
        release_m(0);
        run_txn(0, 1'b0, 32'h0000_2500, 32'h0, lat, rd, er, aw, asel);
        check("p25_lat", lat, 2);
        check("p25_err", er, 1'b1);
        check("p25_rdata", rd, 32'h0);
        release_m(0);
        run_txn(1, 1'b0, 32'h0000_20FF, 32'h0, lat, rd, er, aw, asel);
        check("p20_err", er, 1'b1);
        release_m(1);

        // Reset during the read wait: the read is dropped without an ack.
        @(posedge clk); #1;
        set_m(1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_sel", bus_sel, 5'b0);
        check("abort_addr", bus_addr, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        n_ack = 0;
        repeat (8) begin
            @(negedge clk);
            if (m0_ack || m1_ack) n_ack++;
        end
        check("abort_no_ack", n_ack, 0);
        run_txn(1, 1'b0, 32'h0000_0020, 32'h0, lat, rd, er, aw, asel);
        check("post_abort_lat", lat, 2 + RD_LAT);
        check("post_abort_data", rd, 32'hDEAD_BEEF);
        release_m(1);

        // Contention: both masters keep req high for 4 transactions each.
        ack_q.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(1'(i % 2));
        fork
            begin : c0
                int l0; logic [31:0] r0; bit e0, w0; logic [4:0] s0;
                for (int i = 0; i < 4; i++)
                    run_txn(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, l0, r0, e0, w0, s0);
                release_m(0);
            end
            begin : c1
                int l1; logic [31:0] r1; bit e1, w1; logic [4:0] s1;
                for (int i = 0; i < 4; i++)
                    run_txn(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, l1, r1, e1, w1, s1);
                release_m(1);
            end
        join
        check("contend_count", ack_q.size(), 8);
        for (int i = 0; i < ack_q.size() && i < 8; i++)
            check("contend_order", ack_q[i], exp_q[i]);

        // Randomized traffic with changing slave read data.
        begin : rnd
            bit d0, d1;
            d0 = 0; d1 = 0;
            fork
                begin : r_m0
                    int l0; logic [31:0] r0; bit e0, w0; logic [4:0] s0; int g0;
                    for (int i = 0; i < 25; i++) begin
                        run_txn(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, l0, r0, e0, w0, s0);
                        g0 = $urandom_range(0, 3);
                        if (g0 > 0) begin
                            release_m(0);
                            repeat (g0 - 1) @(posedge clk);
                        end
                    end
                    release_m(0);
                    d0 = 1;
                end
                begin : r_m1
                    int l1; logic [31:0] r1; bit e1, w1; logic [4:0] s1; int g1;
                    for (int i = 0; i < 25; i++) begin
                        run_txn(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, l1, r1, e1, w1, s1);
                        g1 = $urandom_range(0, 3);
                        if (g1 > 0) begin
                            release_m(1);
                            repeat (g1 - 1) @(posedge clk);
                        end
                    end
                    release_m(1);
                    d1 = 1;
                end
                begin : r_data
                    while (!(d0 && d1)) begin
                        @(posedge clk); #1;
                        s_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom};
                    end
                end
            join
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        bad++;
        $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
